// File: rtl/ifid_reg_if.sv
// IF/ID boundary bundle: fetch-side inputs, decode-side outputs, perf counters.
// master = fetch/control side, slave = the IF/ID register.
interface ifid_reg_if #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int EXC_W   = 5,
    parameter int STALL_W = 4
);
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_plus_4;
    logic [EXC_W-1:0]   if_exccode_i;
    logic               if_ice;
    logic [INST_W-1:0]  inst_i;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  id_pc;
    logic [ADDR_W-1:0]  id_pc_plus_4;
    logic [EXC_W-1:0]   id_exccode;
    logic [INST_W-1:0]  id_inst;
    logic               id_valid;
    logic [31:0]        perf_bubble;
    logic [31:0]        perf_hold;

    modport master (
        output if_pc, if_pc_plus_4, if_exccode_i, if_ice,
        output inst_i, stall, flush,
        input  id_pc, id_pc_plus_4, id_exccode, id_inst,
        input  id_valid, perf_bubble, perf_hold
    );

    modport slave (
        input  if_pc, if_pc_plus_4, if_exccode_i, if_ice,
        input  inst_i, stall, flush,
        output id_pc, id_pc_plus_4, id_exccode, id_inst,
        output id_valid, perf_bubble, perf_hold
    );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with instruction-hold buffer for synchronous I-RAM.
// Optional bubble/hold counters enabled by defining IFID_PERF_CNT_EN.
module ifid_reg #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                EXC_W    = 5,
    parameter logic [EXC_W-1:0]  EXC_NONE = 5'h10,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0,
    parameter int                STALL_W  = 4
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst,
    ifid_reg_if.slave  bus
);
    logic [ADDR_W-1:0] r_id_pc;
    logic [ADDR_W-1:0] r_id_pc_plus_4;
    logic [EXC_W-1:0]  r_id_exccode;
    logic              r_id_valid;
    logic              r_hold_v;
    logic [INST_W-1:0] r_hold_inst;
    logic              w_hold;
    logic              w_bubble;

    assign w_hold   = bus.stall[2];
    assign w_bubble = bus.stall[1] & ~bus.stall[2];

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_id_pc        <= '0;
            r_id_pc_plus_4 <= '0;
            r_id_exccode   <= EXC_NONE;
            r_id_valid     <= 1'b0;
            r_hold_v       <= 1'b0;
            r_hold_inst    <= NOP_INST;
        end else if (bus.flush) begin
            r_id_pc        <= '0;
            r_id_pc_plus_4 <= '0;
            r_id_exccode   <= EXC_NONE;
            r_id_valid     <= 1'b0;
            r_hold_v       <= 1'b0;
        end else if (w_hold) begin
            // RAM data is only valid on the first stalled cycle
            if (r_id_valid && !r_hold_v) begin
                r_hold_inst <= bus.inst_i;
                r_hold_v    <= 1'b1;
            end
        end else if (w_bubble) begin
            r_id_pc        <= '0;
            r_id_pc_plus_4 <= '0;
            r_id_exccode   <= EXC_NONE;
            r_id_valid     <= 1'b0;
            r_hold_v       <= 1'b0;
        end else begin
            r_id_pc        <= bus.if_pc;
            r_id_pc_plus_4 <= bus.if_pc_plus_4;
            r_id_exccode   <= bus.if_exccode_i;
            r_id_valid     <= bus.if_ice;
            r_hold_v       <= 1'b0;
        end
    end

    always_comb begin
        bus.id_inst = bus.inst_i;
        if (!r_id_valid || r_id_exccode != EXC_NONE)
            bus.id_inst = NOP_INST;
        else if (r_hold_v)
            bus.id_inst = r_hold_inst;
    end

    assign bus.id_pc        = r_id_pc;
    assign bus.id_pc_plus_4 = r_id_pc_plus_4;
    assign bus.id_exccode   = r_id_exccode;
    assign bus.id_valid     = r_id_valid;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_hold;

    // Flush outranks stalls, so flushed edges count as neither
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_perf_bubble <= '0;
            r_perf_hold   <= '0;
        end else if (!bus.flush) begin
            if (w_bubble)
                r_perf_bubble <= r_perf_bubble + 32'd1;
            if (w_hold && r_id_valid)
                r_perf_hold <= r_perf_hold + 32'd1;
        end
    end

    assign bus.perf_bubble = r_perf_bubble;
    assign bus.perf_hold   = r_perf_hold;
`else
    assign bus.perf_bubble = '0;
    assign bus.perf_hold   = '0;
`endif
endmodule

// File: tb/tb_ifid_reg.sv
// Directed table-driven bench for ifid_reg.
// Each row: inputs held for one cycle, expected outputs seen during that cycle.
module tb_ifid_reg;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] ADEL     = 5'h04;

    logic cpu_clk_50M = 1'b0;
    logic cpu_rst     = 1'b1;
    int   checks      = 0;
    int   failures    = 0;

    ifid_reg_if bus ();

    ifid_reg dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .bus         (bus)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic        rst;
        logic [3:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        ice;
        logic [4:0]  exc;
        logic [31:0] inst;
        logic        chk;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_exc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [3:0] stall, input logic flush,
        input logic [31:0] pc, input logic ice, input logic [4:0] exc,
        input logic [31:0] inst, input logic chk, input logic e_valid,
        input logic [31:0] e_pc, input logic [4:0] e_exc,
        input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.pc = pc;
        v.ice = ice; v.exc = exc; v.inst = inst; v.chk = chk;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_exc = e_exc;
        v.e_inst = e_inst;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] e_pc4;
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst              = v.rst;
        bus.stall            = v.stall;
        bus.flush            = v.flush;
        bus.if_pc            = v.pc;
        bus.if_pc_plus_4     = v.pc + 32'd4;
        bus.if_ice           = v.ice;
        bus.if_exccode_i     = v.exc;
        bus.inst_i           = v.inst;
        @(negedge cpu_clk_50M);
        if (v.chk) begin
            e_pc4 = (v.e_pc == 32'h0) ? 32'h0 : v.e_pc + 32'd4;
            check($sformatf("r%0d_valid", idx), 32'(bus.id_valid),
                  32'(v.e_valid));
            check($sformatf("r%0d_pc", idx), bus.id_pc, v.e_pc);
            check($sformatf("r%0d_pc4", idx), bus.id_pc_plus_4, e_pc4);
            check($sformatf("r%0d_exc", idx), 32'(bus.id_exccode),
                  32'(v.e_exc));
            check($sformatf("r%0d_inst", idx), bus.id_inst, v.e_inst);
        end
    endtask

    initial begin
        logic [31:0] exp_bub;
        logic [31:0] exp_hold;
        bus.stall = '0; bus.flush = 0; bus.if_pc = '0;
        bus.if_pc_plus_4 = '0; bus.if_ice = 0;
        bus.if_exccode_i = EXC_NONE; bus.inst_i = '0;

        // reset
        tbl.push_back(mk(1,4'b0000,0,32'h0,0,EXC_NONE,32'h0,
                         0,0,32'h0,EXC_NONE,32'h0));
        tbl.push_back(mk(1,4'b0000,0,32'h0,0,EXC_NONE,32'h0,
                         1,0,32'h0,EXC_NONE,32'h0));
        // stream
        tbl.push_back(mk(0,4'b0000,0,32'hBFC00000,1,EXC_NONE,32'h11111111,
                         1,0,32'h0,EXC_NONE,32'h0));
        tbl.push_back(mk(0,4'b0000,0,32'hBFC00004,1,EXC_NONE,32'h24010001,
                         1,1,32'hBFC00000,EXC_NONE,32'h24010001));
        // hold for 3 cycles, RAM output turns to garbage
        tbl.push_back(mk(0,4'b0110,0,32'hBFC00008,1,EXC_NONE,32'h24020002,
                         1,1,32'hBFC00004,EXC_NONE,32'h24020002));
        tbl.push_back(mk(0,4'b0110,0,32'hBFC00008,1,EXC_NONE,32'hDEADBEEF,
                         1,1,32'hBFC00004,EXC_NONE,32'h24020002));
        tbl.push_back(mk(0,4'b0110,0,32'hBFC00008,1,EXC_NONE,32'hDEADBEEF,
                         1,1,32'hBFC00004,EXC_NONE,32'h24020002));
        // release: same-cycle load
        tbl.push_back(mk(0,4'b0000,0,32'hBFC00008,1,EXC_NONE,32'hDEADBEEF,
                         1,1,32'hBFC00004,EXC_NONE,32'h24020002));
        // bubble
        tbl.push_back(mk(0,4'b0010,0,32'hBFC0000C,1,EXC_NONE,32'h24030003,
                         1,1,32'hBFC00008,EXC_NONE,32'h24030003));
        tbl.push_back(mk(0,4'b0000,0,32'hBFC0000C,1,EXC_NONE,32'h55555555,
                         1,0,32'h0,EXC_NONE,32'h0));
        // flush during hold
        tbl.push_back(mk(0,4'b0110,1,32'hBFC00010,1,EXC_NONE,32'h24040004,
                         1,1,32'hBFC0000C,EXC_NONE,32'h24040004));
        tbl.push_back(mk(0,4'b0000,0,32'hBFC00380,1,EXC_NONE,32'h66666666,
                         1,0,32'h0,EXC_NONE,32'h0));
        // misaligned fetch
        tbl.push_back(mk(0,4'b0000,0,32'hBFC00002,1,ADEL,32'h40800000,
                         1,1,32'hBFC00380,EXC_NONE,32'h40800000));
        // ice=0 load
        tbl.push_back(mk(0,4'b0000,0,32'hBFC00004,0,EXC_NONE,32'h77777777,
                         1,1,32'hBFC00002,ADEL,32'h0));
        tbl.push_back(mk(0,4'b0000,0,32'h0,0,EXC_NONE,32'h88888888,
                         1,0,32'hBFC00004,EXC_NONE,32'h0));

        foreach (tbl[i]) apply(tbl[i], i);

`ifdef IFID_PERF_CNT_EN
        exp_hold = 32'd3;
        exp_bub  = 32'd1;
`else
        exp_hold = 32'd0;
        exp_bub  = 32'd0;
`endif
        check("perf_hold", bus.perf_hold, exp_hold);
        check("perf_bubble", bus.perf_bubble, exp_bub);

        // reset in the middle of a hold discards the held instruction
        apply(mk(0,4'b0000,0,32'h00000100,1,EXC_NONE,32'h0,
                 0,0,32'h0,EXC_NONE,32'h0), 100);
        apply(mk(0,4'b0110,0,32'h00000104,1,EXC_NONE,32'hAAAA0001,
                 1,1,32'h00000100,EXC_NONE,32'hAAAA0001), 101);
        apply(mk(1,4'b0110,0,32'h00000104,1,EXC_NONE,32'hBBBB0002,
                 1,1,32'h00000100,EXC_NONE,32'hAAAA0001), 102);
        apply(mk(0,4'b0000,0,32'h00000200,1,EXC_NONE,32'hCCCC0003,
                 1,0,32'h0,EXC_NONE,32'h0), 103);
        apply(mk(0,4'b0000,0,32'h00000204,1,EXC_NONE,32'hDDDD0004,
                 1,1,32'h00000200,EXC_NONE,32'hDDDD0004), 104);
        check("perf_hold_rst", bus.perf_hold, 32'd0);
        check("perf_bubble_rst", bus.perf_bubble, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
